// File: rtl/waffle_pkg.sv
// Shared types and default sizing for the waffle solver and its sequencer.
package waffle_pkg;

    // Default image geometry and timing, used as parameter defaults by the design.
    localparam int DEF_IMG_ROWS     = 2;
    localparam int DEF_IMG_COLS     = 4;
    localparam int DEF_ADDR_W       = 32;
    localparam int DEF_SOLVE_CYCLES = 4;

    // Number of image words fetched per job at the default geometry.
    localparam int NUM_WORDS = DEF_IMG_ROWS * DEF_IMG_COLS;

    typedef logic signed [31:0] word_t;

    typedef enum logic [2:0] {
        IDLE,
        FETCH_REQ,
        FETCH_WAIT,
        SOLVE,
        DONE
    } ctrl_state_e;

endpackage

// File: rtl/waffle_solver.sv
// Combinational max-sum subrectangle over a small signed image.
// The empty rectangle is always allowed, so the answer is never negative.
module waffle_solver
    import waffle_pkg::*;
#(
    parameter int IMG_ROWS = DEF_IMG_ROWS,
    parameter int IMG_COLS = DEF_IMG_COLS
) (
    input  word_t memory_input [IMG_ROWS][IMG_COLS],
    output word_t max_sum
);

    // For each row band, accumulate column sums and scan every column span.
    function automatic word_t best_rect(input word_t img [IMG_ROWS][IMG_COLS]);
        word_t best;
        word_t run;
        word_t col_sum [IMG_COLS];
        best = '0;
        for (int r1 = 0; r1 < IMG_ROWS; r1++) begin
            for (int c = 0; c < IMG_COLS; c++) begin
                col_sum[c] = '0;
            end
            for (int r2 = r1; r2 < IMG_ROWS; r2++) begin
                for (int c = 0; c < IMG_COLS; c++) begin
                    col_sum[c] = col_sum[c] + img[r2][c];
                end
                for (int c1 = 0; c1 < IMG_COLS; c1++) begin
                    run = '0;
                    for (int c2 = c1; c2 < IMG_COLS; c2++) begin
                        run = run + col_sum[c2];
                        if (run > best) begin
                            best = run;
                        end
                    end
                end
            end
        end
        return best;
    endfunction

    // Pure combinational evaluation of the buffered image.
    always_comb begin
        max_sum = best_rect(memory_input);
    end

endmodule

// File: rtl/waffle_solver_ctrl.sv
// Sequencer around waffle_solver: fetches the image word by word into a
// register buffer, holds it stable for a fixed settle window, captures the
// solver output and returns it over a valid/ready handshake.
module waffle_solver_ctrl
    import waffle_pkg::*;
#(
    parameter int IMG_ROWS     = DEF_IMG_ROWS,
    parameter int IMG_COLS     = DEF_IMG_COLS,
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int SOLVE_CYCLES = DEF_SOLVE_CYCLES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              busy,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [31:0]       result
);

    localparam int N_WORDS = IMG_ROWS * IMG_COLS;
    localparam int IDX_W   = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    localparam int CNT_W   = $clog2(SOLVE_CYCLES) + 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SOLVE_CYCLES - 1);

    ctrl_state_e       state_q;
    ctrl_state_e       state_d;
    logic [ADDR_W-1:0] base_q;
    logic [IDX_W-1:0]  idx_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [31:0]       result_q;
    word_t             buffer [IMG_ROWS][IMG_COLS];
    word_t             solver_out;

    logic word_accept;
    logic last_word;
    logic solve_end;

    assign word_accept = (state_q == FETCH_WAIT) && mem_rvalid;
    assign last_word   = (idx_q == LAST_IDX);
    assign solve_end   = (state_q == SOLVE) && (cnt_q == LAST_CNT);

    // The solver only ever sees registered buffer contents.
    waffle_solver #(
        .IMG_ROWS (IMG_ROWS),
        .IMG_COLS (IMG_COLS)
    ) u_solver (
        .memory_input (buffer),
        .max_sum      (solver_out)
    );

    // State register; reset aborts any job in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic for the fetch / solve / handshake sequence.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FETCH_REQ;
                end
            end
            FETCH_REQ: begin
                state_d = FETCH_WAIT;
            end
            FETCH_WAIT: begin
                if (mem_rvalid) begin
                    state_d = last_word ? SOLVE : FETCH_REQ;
                end
            end
            SOLVE: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Job bookkeeping: base address, word index, settle counter and result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q   <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            if ((state_q == IDLE) && start) begin
                base_q <= base_addr;
                idx_q  <= '0;
            end
            if (word_accept) begin
                if (last_word) begin
                    cnt_q <= '0;
                end else begin
                    idx_q <= idx_q + 1'b1;
                end
            end
            if (state_q == SOLVE) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (solve_end) begin
                result_q <= solver_out;
            end
        end
    end

    // Image buffer, written one word at a time in row-major order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < IMG_ROWS; r++) begin
                for (int c = 0; c < IMG_COLS; c++) begin
                    buffer[r][c] <= '0;
                end
            end
        end else begin
            for (int r = 0; r < IMG_ROWS; r++) begin
                for (int c = 0; c < IMG_COLS; c++) begin
                    if (word_accept && (idx_q == IDX_W'(r * IMG_COLS + c))) begin
                        buffer[r][c] <= $signed(mem_rdata);
                    end
                end
            end
        end
    end

    assign busy      = (state_q != IDLE);
    assign mem_req   = (state_q == FETCH_REQ);
    assign mem_addr  = mem_req ? (base_q + ADDR_W'(idx_q)) : '0;
    assign res_valid = (state_q == DONE);
    assign result    = result_q;

endmodule

// File: tb/tb_waffle_solver_ctrl.sv
// Scoreboard bench for waffle_solver_ctrl: a behavioural memory answers
// requests, stimulus pushes expected addresses and results into queues,
// and independent monitors pop and compare as the DUT presents them.
module tb_waffle_solver_ctrl;
    import waffle_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] base_addr;
    logic        busy;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] result;

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;

    logic [31:0] exp_addr_q [$];
    logic [31:0] exp_res_q  [$];

    word_t       mem_img [NUM_WORDS];
    logic [31:0] mem_base     = '0;
    int          mem_lat      = 1;
    bit          mem_lat_rand = 1'b0;
    int          rv_count     = 0;
    int          req_count    = 0;

    word_t img_v [NUM_WORDS];

    waffle_solver_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .busy       (busy),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .result     (result)
    );

    // Free-running clock and cycle counter.
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic reportFail(input string name, input string detail);
        checks++;
        failures++;
        $display("[TB] FAIL %s %s", name, detail);
    endtask

    // Behavioural memory: answers each request 2+L cycles after it is issued.
    initial begin
        logic [31:0] a;
        logic [31:0] off;
        int          lat;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(negedge clk);
            if (rst_n && mem_req) begin
                a   = mem_addr;
                lat = mem_lat_rand ? int'($urandom_range(6, 1)) : mem_lat;
                repeat (lat + 1) @(posedge clk);
                #1;
                off        = a - mem_base;
                mem_rvalid = 1'b1;
                mem_rdata  = mem_img[off % NUM_WORDS];
                rv_count++;
                @(posedge clk);
                #1;
                mem_rvalid = 1'b0;
                mem_rdata  = '0;
            end
        end
    end

    // Address monitor: each request pops the next expected address.
    initial begin
        logic prev_req;
        prev_req = 1'b0;
        forever begin
            @(negedge clk);
            if (mem_req) begin
                req_count++;
                checkOutput("mem_req_single_cycle", {31'b0, prev_req}, 32'd0);
                if (exp_addr_q.size() == 0) begin
                    reportFail("unexpected_mem_req", $sformatf("actual_addr=%0h required=none", mem_addr));
                end else begin
                    checkOutput("mem_addr", mem_addr, exp_addr_q.pop_front());
                end
            end
            prev_req = mem_req;
        end
    end

    // Result monitor: every accepted result pops the next expected value.
    initial begin
        forever begin
            @(negedge clk);
            if (res_valid && res_ready) begin
                if (exp_res_q.size() == 0) begin
                    reportFail("unexpected_result", $sformatf("actual=%0h required=none", result));
                end else begin
                    checkOutput("result", result, exp_res_q.pop_front());
                end
            end
        end
    end

    task automatic loadJob(input word_t img [NUM_WORDS], input logic [31:0] base,
                           input logic [31:0] exp_res, input bit push_res);
        mem_img  = img;
        mem_base = base;
        for (int i = 0; i < NUM_WORDS; i++) begin
            exp_addr_q.push_back(base + 32'(i));
        end
        if (push_res) begin
            exp_res_q.push_back(exp_res);
        end
    endtask

    // One complete job with res_ready high; exp_lat < 0 skips the latency check.
    task automatic applyStimulus(input word_t img [NUM_WORDS], input logic [31:0] base,
                                 input logic [31:0] exp_res, input int exp_lat);
        int t0;
        int n;
        loadJob(img, base, exp_res, 1'b1);
        @(posedge clk);
        #1;
        base_addr = base;
        start     = 1'b1;
        t0        = cycle;
        @(posedge clk);
        #1;
        start     = 1'b0;
        base_addr = ~base;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!res_valid && n < 2000);
        if (!res_valid) begin
            reportFail("res_valid_timeout", "actual=0 required=1");
        end else if (exp_lat >= 0) begin
            checkOutput("start_to_res_valid", 32'(cycle - t0), 32'(exp_lat));
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 20);
        checkOutput("busy_after_accept", {31'b0, busy}, 32'd0);
        checkOutput("res_valid_after_accept", {31'b0, res_valid}, 32'd0);
        @(negedge clk);
    endtask

    // Global time limit so the bench always terminates.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "[TB] watchdog");
    end

    // Directed scenarios.
    initial begin
        int n;
        int rv0;
        rst_n     = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        res_ready = 1'b1;

        repeat (3) @(negedge clk);
        checkOutput("reset_busy", {31'b0, busy}, 32'd0);
        checkOutput("reset_mem_req", {31'b0, mem_req}, 32'd0);
        checkOutput("reset_res_valid", {31'b0, res_valid}, 32'd0);
        checkOutput("reset_mem_addr", mem_addr, 32'd0);
        checkOutput("reset_result", result, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] test 1: all ones, 1-cycle memory");
        mem_lat = 1;
        img_v = '{1, 1, 1, 1, 1, 1, 1, 1};
        applyStimulus(img_v, 32'h0000_0100, 32'd8, 29);

        $display("[TB] test 2: all -5");
        img_v = '{-5, -5, -5, -5, -5, -5, -5, -5};
        applyStimulus(img_v, 32'h0000_2000, 32'd0, 29);

        $display("[TB] test 3: single 7, random latency");
        mem_lat_rand = 1'b1;
        req_count    = 0;
        img_v = '{-1, -1, -1, -1, -1, -1, 7, -1};
        applyStimulus(img_v, 32'h0000_0500, 32'd7, -1);
        checkOutput("mem_req_pulse_count", 32'(req_count), 32'd8);
        mem_lat_rand = 1'b0;

        $display("[TB] test 4: stalled consumer and ignored start pulses");
        mem_lat = 2;
        res_ready = 1'b0;
        img_v = '{1, -2, 3, 4, -1, 5, -6, 2};
        loadJob(img_v, 32'h0000_0040, 32'd7, 1'b1);
        @(posedge clk);
        #1;
        base_addr = 32'h0000_0040;
        start     = 1'b1;
        n = 0;
        while (!res_valid && n < 2000) begin
            @(posedge clk);
            #1;
            start     = ~start;
            base_addr = 32'h0000_9000;
            n++;
        end
        if (!res_valid) begin
            reportFail("stall_res_valid_timeout", "actual=0 required=1");
        end
        repeat (10) begin
            @(posedge clk);
            #1;
            start = ~start;
            @(negedge clk);
            checkOutput("stall_res_valid", {31'b0, res_valid}, 32'd1);
            checkOutput("stall_result", result, 32'd7);
        end
        @(posedge clk);
        #1;
        start     = 1'b1;
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("busy_after_ignored_start", {31'b0, busy}, 32'd0);
        checkOutput("result_held_in_idle", result, 32'd7);

        $display("[TB] test 5: reset during fetch");
        mem_lat = 6;
        img_v = '{100, 100, 100, 100, 100, 100, 100, 100};
        loadJob(img_v, 32'h0000_0700, 32'd0, 1'b0);
        rv0 = rv_count;
        @(posedge clk);
        #1;
        base_addr = 32'h0000_0700;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0;
        while (rv_count < rv0 + 3 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (!mem_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!mem_req) begin
            reportFail("fourth_req_timeout", "actual=0 required=1");
        end
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", {31'b0, busy}, 32'd0);
        checkOutput("abort_mem_req", {31'b0, mem_req}, 32'd0);
        checkOutput("abort_res_valid", {31'b0, res_valid}, 32'd0);
        checkOutput("abort_mem_addr", mem_addr, 32'd0);
        checkOutput("abort_result", result, 32'd0);
        exp_addr_q.delete();
        exp_res_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        checkOutput("late_rvalid_busy", {31'b0, busy}, 32'd0);
        checkOutput("late_rvalid_res_valid", {31'b0, res_valid}, 32'd0);
        img_v = '{10, -20, 30, -1, 5, 5, -100, 40};
        applyStimulus(img_v, 32'h0000_0300, 32'd40, 69);

        $display("[TB] test 6: address wrap");
        mem_lat = 1;
        img_v = '{2, 2, 2, 2, -3, -3, -3, -3};
        applyStimulus(img_v, 32'hFFFF_FFFE, 32'd8, 29);

        repeat (5) @(negedge clk);
        checkOutput("addr_queue_drained", 32'(exp_addr_q.size()), 32'd0);
        checkOutput("result_queue_drained", 32'(exp_res_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
